// File: rtl/decode_sel_pkg.sv
// Shared types and constants for the round-robin arbiter in front of the Q/R/S/T select decoder.
// The decoder input is {A,B,C,D} = code[3:0].
package decode_sel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] IDLE_CODE = 4'b0001;
    localparam logic [3:0] CODE_CH0  = 4'b0000;
    localparam logic [3:0] CODE_CH1  = 4'b1000;
    localparam logic [3:0] CODE_CH2  = 4'b0100;
    localparam logic [3:0] CODE_CH3  = 4'b0010;

    function automatic logic [3:0] chan_code(input logic [1:0] idx);
        logic [3:0] c;
        case (idx)
            2'd0:    c = CODE_CH0;
            2'd1:    c = CODE_CH1;
            2'd2:    c = CODE_CH2;
            default: c = CODE_CH3;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping mod 4.
// The 'last' channel itself is searched last so it gets lowest priority.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = last;
        cand  = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/decode_sel_arbiter.sv
// Round-robin arbiter sharing the select decoder between four requesters, with bounded
// dwell per grant and an idle-code dead time between grants.
module decode_sel_arbiter
    import decode_sel_pkg::*;
#(
    parameter int HOLD_MAX   = 16,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [3:0] code,
    output logic       busy,
    output logic [1:0] last
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       gnt_n, code_n;
    logic [1:0]       last_n;
    logic             pick_valid;
    logic [1:0]       pick_idx;

    rr_pick4 u_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            gnt   <= 4'b0000;
            code  <= IDLE_CODE;
            busy  <= 1'b0;
            last  <= 2'd3;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            code  <= code_n;
            busy  <= (state_n != IDLE);
            last  <= last_n;
        end
    end

    // While granted, 'last' is the current winner, so req[last] is the holder's request.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gnt_n   = gnt;
        code_n  = code;
        last_n  = last;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n = GRANT;
                    gnt_n   = 4'b0001 << pick_idx;
                    code_n  = chan_code(pick_idx);
                    last_n  = pick_idx;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (!req[last] || cnt == HOLD_LAST) begin
                    state_n = GAP;
                    gnt_n   = 4'b0000;
                    code_n  = IDLE_CODE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
                code_n  = IDLE_CODE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_decode_sel_arbiter.sv
// Directed bench for decode_sel_arbiter: default instance plus a HOLD_MAX=1/GAP_CYCLES=2 instance.
module tb_decode_sel_arbiter;

    logic       clk;
    logic       rst, rst2;
    logic [3:0] req, req2;
    logic [3:0] gnt, code, gnt2, code2;
    logic       busy, busy2;
    logic [1:0] last, last2;
    logic [10:0] obs, obs2;
    int total, bad;

    decode_sel_arbiter dut (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt), .code(code), .busy(busy), .last(last)
    );

    decode_sel_arbiter #(.HOLD_MAX(1), .GAP_CYCLES(2), .CNT_W(5)) dut2 (
        .clk(clk), .rst(rst2), .req(req2),
        .gnt(gnt2), .code(code2), .busy(busy2), .last(last2)
    );

    assign obs  = {gnt, code, busy, last};
    assign obs2 = {gnt2, code2, busy2, last2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {gnt, code, busy, last} while channel ch is granted.
    function automatic logic [10:0] on_vec(input int ch);
        logic [3:0] g, c;
        case (ch)
            0:       begin g = 4'b0001; c = 4'b0000; end
            1:       begin g = 4'b0010; c = 4'b1000; end
            2:       begin g = 4'b0100; c = 4'b0100; end
            default: begin g = 4'b1000; c = 4'b0010; end
        endcase
        return {g, c, 1'b1, 2'(ch)};
    endfunction

    // Expected vector with no grant: idle code, given busy and pointer.
    function automatic logic [10:0] off_vec(input logic b, input int l);
        return {4'b0000, 4'b0001, b, 2'(l)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b0000;
        step(); step();
        total++;
        if (obs !== off_vec(1'b0, 3)) begin bad++; $display("FAIL reset got=%b exp=%b", obs, off_vec(1'b0, 3)); end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (obs !== off_vec(1'b0, 3)) begin bad++; $display("FAIL idle_hold[%0d] got=%b exp=%b", i, obs, off_vec(1'b0, 3)); end
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        for (int i = 0; i < 16; i++) begin
            step();
            total++;
            if (obs !== on_vec(2)) begin bad++; $display("FAIL single_grant[%0d] got=%b exp=%b", i, obs, on_vec(2)); end
        end
        step(); total++;
        if (obs !== off_vec(1'b1, 2)) begin bad++; $display("FAIL single_gap got=%b exp=%b", obs, off_vec(1'b1, 2)); end
        step(); total++;
        if (obs !== off_vec(1'b0, 2)) begin bad++; $display("FAIL single_idle got=%b exp=%b", obs, off_vec(1'b0, 2)); end
        // Regrant, then drop req exactly when the dwell limit is reached.
        for (int i = 0; i < 16; i++) begin
            step();
            total++;
            if (obs !== on_vec(2)) begin bad++; $display("FAIL single_regrant[%0d] got=%b exp=%b", i, obs, on_vec(2)); end
        end
        req = 4'b0000;
        step(); total++;
        if (obs !== off_vec(1'b1, 2)) begin bad++; $display("FAIL both_gap got=%b exp=%b", obs, off_vec(1'b1, 2)); end
        step(); total++;
        if (obs !== off_vec(1'b0, 2)) begin bad++; $display("FAIL both_idle got=%b exp=%b", obs, off_vec(1'b0, 2)); end
        step(); total++;
        if (obs !== off_vec(1'b0, 2)) begin bad++; $display("FAIL both_stay_idle got=%b exp=%b", obs, off_vec(1'b0, 2)); end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        step(); total++;
        if (obs !== off_vec(1'b0, 3)) begin bad++; $display("FAIL rr_reset got=%b exp=%b", obs, off_vec(1'b0, 3)); end
        rst = 1'b0; req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 16; i++) begin
                step();
                total++;
                if (obs !== on_vec(order[n])) begin bad++; $display("FAIL rr_grant[%0d.%0d] got=%b exp=%b", n, i, obs, on_vec(order[n])); end
                total++;
                if ($countones(gnt) > 1 || $countones(code) > 1) begin bad++; $display("FAIL rr_onehot gnt=%b code=%b exp=at most one bit", gnt, code); end
            end
            step(); total++;
            if (obs !== off_vec(1'b1, order[n])) begin bad++; $display("FAIL rr_gap[%0d] got=%b exp=%b", n, obs, off_vec(1'b1, order[n])); end
            step(); total++;
            if (obs !== off_vec(1'b0, order[n])) begin bad++; $display("FAIL rr_idle[%0d] got=%b exp=%b", n, obs, off_vec(1'b0, order[n])); end
        end
        req = 4'b0000;
        step(); total++;
        if (obs !== off_vec(1'b0, 0)) begin bad++; $display("FAIL rr_drain got=%b exp=%b", obs, off_vec(1'b0, 0)); end
    endtask

    task automatic test_early_release();
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step(); total++;
            if (obs !== on_vec(1)) begin bad++; $display("FAIL early_grant[%0d] got=%b exp=%b", i, obs, on_vec(1)); end
        end
        req = 4'b1000;
        step(); total++;
        if (obs !== off_vec(1'b1, 1)) begin bad++; $display("FAIL early_gap got=%b exp=%b", obs, off_vec(1'b1, 1)); end
        step(); total++;
        if (obs !== off_vec(1'b0, 1)) begin bad++; $display("FAIL early_idle got=%b exp=%b", obs, off_vec(1'b0, 1)); end
        step(); total++;
        if (obs !== on_vec(3)) begin bad++; $display("FAIL early_next got=%b exp=%b", obs, on_vec(3)); end
        req = 4'b0000;
        step(); total++;
        if (obs !== off_vec(1'b1, 3)) begin bad++; $display("FAIL early_drop_gap got=%b exp=%b", obs, off_vec(1'b1, 3)); end
        step(); total++;
        if (obs !== off_vec(1'b0, 3)) begin bad++; $display("FAIL early_drop_idle got=%b exp=%b", obs, off_vec(1'b0, 3)); end
    endtask

    task automatic test_reset_mid_grant();
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            step(); total++;
            if (obs !== on_vec(0)) begin bad++; $display("FAIL mid_grant[%0d] got=%b exp=%b", i, obs, on_vec(0)); end
        end
        rst = 1'b1;
        step(); total++;
        if (obs !== off_vec(1'b0, 3)) begin bad++; $display("FAIL mid_reset got=%b exp=%b", obs, off_vec(1'b0, 3)); end
        rst = 1'b0;
        step(); total++;
        if (obs !== on_vec(0)) begin bad++; $display("FAIL mid_regrant got=%b exp=%b", obs, on_vec(0)); end
        req = 4'b0000;
        step(); total++;
        if (obs !== off_vec(1'b1, 0)) begin bad++; $display("FAIL mid_gap got=%b exp=%b", obs, off_vec(1'b1, 0)); end
        step(); total++;
        if (obs !== off_vec(1'b0, 0)) begin bad++; $display("FAIL mid_idle got=%b exp=%b", obs, off_vec(1'b0, 0)); end
    endtask

    task automatic test_hold_one();
        int order[4] = '{0, 1, 0, 1};
        rst2 = 1'b1; req2 = 4'b0000;
        step(); total++;
        if (obs2 !== off_vec(1'b0, 3)) begin bad++; $display("FAIL h1_reset got=%b exp=%b", obs2, off_vec(1'b0, 3)); end
        rst2 = 1'b0; req2 = 4'b0011;
        for (int n = 0; n < 4; n++) begin
            step(); total++;
            if (obs2 !== on_vec(order[n])) begin bad++; $display("FAIL h1_grant[%0d] got=%b exp=%b", n, obs2, on_vec(order[n])); end
            for (int g = 0; g < 2; g++) begin
                step(); total++;
                if (obs2 !== off_vec(1'b1, order[n])) begin bad++; $display("FAIL h1_gap[%0d.%0d] got=%b exp=%b", n, g, obs2, off_vec(1'b1, order[n])); end
            end
            step(); total++;
            if (obs2 !== off_vec(1'b0, order[n])) begin bad++; $display("FAIL h1_idle[%0d] got=%b exp=%b", n, obs2, off_vec(1'b0, order[n])); end
        end
        req2 = 4'b0000;
        step(); total++;
        if (obs2 !== off_vec(1'b0, 1)) begin bad++; $display("FAIL h1_drain got=%b exp=%b", obs2, off_vec(1'b0, 1)); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; rst2 = 1'b1;
        req = 4'b0000; req2 = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_early_release();
        test_reset_mid_grant();
        test_hold_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
